axindemux: RTL and testbench



---
 rtl/axin_pkg.sv | 16 +
 rtl/axindemux_onehot_lsb.sv | 24 ++
 rtl/axindemux.sv | 147 ++++++++++++++
 tb/tb_axindemux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axin_pkg.sv
// axin_pkg: shared definitions for the AXI-network demultiplexer.
// Holds the packet FSM state encoding and the byte-count width helper.
package axin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } axin_state_t;

    // Width of the byte-count field for a DW-bit beat; at least one bit.
    function automatic int axin_wbits(input int dw);
        return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
    endfunction

endpackage

// File: rtl/axindemux_onehot_lsb.sv
// onehot_lsb: isolates the lowest set bit of a W-bit vector.
// Used by axindemux to force unicast routing when multicast is compiled out.
module onehot_lsb #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    logic w_found;

    // Scan from bit 0 upward and keep only the first set bit.
    always_comb begin
        o_out   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i_in[i] && !w_found) begin
                o_out[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axindemux.sv
// axindemux: routes one packet stream to a subset of NOUT sinks, choosing
// the destination mask on the first beat of each packet. Aborts propagate to
// every port already receiving the packet; empty-mask packets are dropped.
// Build option: define AXINDEMUX_MULTICAST_EN to honour multi-hot S_SEL;
// otherwise only the lowest set bit of S_SEL is used (unicast).
module axindemux
    import axin_pkg::*;
#(
    parameter int NOUT         = 4,
    parameter int DW           = 64,
    parameter int WBITS        = axin_wbits(DW),
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [DW-1:0]    S_DATA,
    input  logic [WBITS-1:0] S_BYTES,
    input  logic             S_LAST,
    input  logic             S_ABORT,
    input  logic [NOUT-1:0]  S_SEL,
    output logic [NOUT-1:0]  M_VALID,
    input  logic [NOUT-1:0]  M_READY,
    output logic [DW-1:0]    M_DATA,
    output logic [WBITS-1:0] M_BYTES,
    output logic             M_LAST,
    output logic [NOUT-1:0]  M_ABORT
);

    axin_state_t      r_state, w_state_nxt;
    logic [NOUT-1:0]  w_sel;
    logic [NOUT-1:0]  r_route;
    logic [NOUT-1:0]  r_mvalid, w_mvalid_nxt;
    logic [NOUT-1:0]  r_mabort;
    logic [NOUT-1:0]  w_fwd_mask;
    logic [DW-1:0]    r_data;
    logic [WBITS-1:0] r_bytes;
    logic             r_last;
    logic             w_stall, w_take, w_fwd, w_abort_route;

`ifdef AXINDEMUX_MULTICAST_EN
    assign w_sel = S_SEL;
`else
    onehot_lsb #(.W(NOUT)) u_sel (
        .i_in  (S_SEL),
        .o_out (w_sel)
    );
`endif

    // A beat may only advance once every port still holding the prior beat takes it.
    assign w_stall       = |(r_mvalid & ~M_READY);
    assign S_READY       = (r_state == ST_DROP) || !w_stall;
    assign w_take        = S_VALID && S_READY && !S_ABORT;
    assign w_abort_route = (r_state == ST_ROUTE) && S_ABORT;

    // Next-state logic; abort outranks S_LAST while a packet is being routed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take && !S_LAST)
                    w_state_nxt = (w_sel != '0) ? ST_ROUTE : ST_DROP;
            end
            ST_ROUTE: begin
                if (S_ABORT)
                    w_state_nxt = ST_IDLE;
                else if (w_take && S_LAST)
                    w_state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if (S_ABORT || (S_VALID && S_LAST))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Destination of the beat being accepted this cycle and resulting valid bits.
    always_comb begin
        w_fwd_mask = '0;
        if (w_take) begin
            case (r_state)
                ST_IDLE:  w_fwd_mask = w_sel;
                ST_ROUTE: w_fwd_mask = r_route;
                default:  w_fwd_mask = '0;
            endcase
        end
        w_fwd        = |w_fwd_mask;
        w_mvalid_nxt = r_mvalid & ~M_READY;
        if (w_abort_route)
            w_mvalid_nxt = '0;
        else if (w_fwd)
            w_mvalid_nxt = w_fwd_mask;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Latch the route mask from the first beat of every packet.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_route <= '0;
        else if (r_state == ST_IDLE && w_take)
            r_route <= w_sel;
    end

    // Per-port valid bits and the one-cycle abort pulse to the routed ports.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mvalid <= '0;
            r_mabort <= '0;
        end else begin
            r_mvalid <= w_mvalid_nxt;
            r_mabort <= w_abort_route ? r_route : '0;
        end
    end

    // Shared data holding register; optionally zeroed when no port is valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_data  <= '0;
            r_bytes <= '0;
            r_last  <= 1'b0;
        end else if (w_fwd) begin
            r_data  <= S_DATA;
            r_bytes <= S_BYTES;
            r_last  <= S_LAST;
        end else if (OPT_LOWPOWER && (w_mvalid_nxt == '0)) begin
            r_data  <= '0;
            r_bytes <= '0;
            r_last  <= 1'b0;
        end
    end

    assign M_VALID = r_mvalid;
    assign M_ABORT = r_mabort;
    assign M_DATA  = r_data;
    assign M_BYTES = r_bytes;
    assign M_LAST  = r_last;

endmodule

// File: tb/tb_axindemux.sv
// tb_axindemux: scoreboard bench for axindemux. The driver pushes the
// expected beat into each destination port's queue as it is accepted; a
// negedge monitor pops and compares on every port handshake and abort pulse.
// Expectations follow AXINDEMUX_MULTICAST_EN when it is defined.
module tb_axindemux;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  bytes;
        logic        last;
    } beat_t;

`ifdef AXINDEMUX_MULTICAST_EN
    localparam logic [3:0] MC_EXP   = 4'b1010;
    localparam int         MC_STALL = 2;
`else
    localparam logic [3:0] MC_EXP   = 4'b0010;
    localparam int         MC_STALL = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        s_valid, s_ready, s_last, s_abort;
    logic [63:0] s_data;
    logic [2:0]  s_bytes;
    logic [3:0]  s_sel;
    logic [3:0]  m_valid, m_ready, m_abort;
    logic [63:0] m_data;
    logic [2:0]  m_bytes;
    logic        m_last;

    beat_t      q[4][$];
    logic [3:0] aq[$];
    beat_t      mon_e;
    int         n_pass  = 0;
    int         n_total = 0;
    int         st;

    axindemux #(
        .NOUT         (4),
        .DW           (64),
        .WBITS        (3),
        .OPT_LOWPOWER (1'b0)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .S_VALID   (s_valid),
        .S_READY   (s_ready),
        .S_DATA    (s_data),
        .S_BYTES   (s_bytes),
        .S_LAST    (s_last),
        .S_ABORT   (s_abort),
        .S_SEL     (s_sel),
        .M_VALID   (m_valid),
        .M_READY   (m_ready),
        .M_DATA    (m_data),
        .M_BYTES   (m_bytes),
        .M_LAST    (m_last),
        .M_ABORT   (m_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present one beat, wait (bounded) for acceptance, record expectations.
    task automatic send_beat(input logic [3:0] sel, input logic [63:0] d, input logic last,
                             input logic [3:0] exp_mask, output int stalls);
        beat_t b;
        s_valid = 1'b1; s_sel = sel; s_data = d; s_last = last;
        s_bytes = last ? 3'd5 : 3'd0;
        b = '{data: d, bytes: s_bytes, last: last};
        stalls = 0;
        @(negedge clk);
        while (!s_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        chk("s_ready_wait", s_ready, 1'b1);
        if (s_ready)
            for (int k = 0; k < 4; k++)
                if (exp_mask[k]) q[k].push_back(b);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Monitor: every port handshake and abort pulse must match the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && m_ready[k]) begin
                if (q[k].size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat p%0d: got data %0h expected no beat", k, m_data);
                end else begin
                    mon_e = q[k].pop_front();
                    chk($sformatf("beat_p%0d", k), {m_data, m_bytes, m_last}, mon_e);
                end
            end
        end
        if (m_abort != 4'b0000) begin
            if (aq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_abort: got %b expected 0000", m_abort);
            end else begin
                chk("abort", m_abort, aq.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0;
        s_data = '0; s_bytes = '0; s_sel = '0; m_ready = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mvalid", m_valid, 4'b0000);
        chk("rst_mabort", m_abort, 4'b0000);
        chk("rst_sready", s_ready, 1'b1);
        @(posedge clk); #1;

        // Unicast 3-beat packet to port 2, back to back.
        for (int i = 0; i < 3; i++) begin
            send_beat(4'b0100, 64'hA000 + 64'(i), (i == 2), 4'b0100, st);
            chk("uni_stall", st, 0);
        end
        @(negedge clk);
        chk("uni_last_valid", m_valid, 4'b0100);
        chk("uni_last_flag", m_last, 1'b1);
        @(posedge clk); #1;

        // Backpressure: port 0 holds beat 2 for 4 cycles.
        send_beat(4'b0001, 64'hB000, 1'b0, 4'b0001, st);
        send_beat(4'b0001, 64'hB001, 1'b0, 4'b0001, st);
        m_ready[0] = 1'b0;
        fork
            begin repeat (4) @(posedge clk); #1 m_ready[0] = 1'b1; end
        join_none
        send_beat(4'b0001, 64'hB002, 1'b1, 4'b0001, st);
        chk("bp_stall", st, 4);
        repeat (2) @(posedge clk); #1;

        // Multi-hot select; port 3 slow by 2 cycles.
        m_ready[3] = 1'b0;
        send_beat(4'b1010, 64'hC000, 1'b0, MC_EXP, st);
        fork
            begin repeat (2) @(posedge clk); #1 m_ready[3] = 1'b1; end
        join_none
        send_beat(4'b1010, 64'hC001, 1'b1, MC_EXP, st);
        chk("mc_stall", st, MC_STALL);
        repeat (2) @(posedge clk); #1;

        // Empty mask: 5 beats dropped, then a normal packet.
        for (int i = 0; i < 5; i++) begin
            send_beat(4'b0000, 64'hD000 + 64'(i), (i == 4), 4'b0000, st);
            chk("drop_stall", st, 0);
        end
        @(negedge clk);
        chk("drop_mvalid", m_valid, 4'b0000);
        @(posedge clk); #1;
        send_beat(4'b0001, 64'hD100, 1'b0, 4'b0001, st);
        send_beat(4'b0001, 64'hD101, 1'b1, 4'b0001, st);
        repeat (2) @(posedge clk); #1;

        // Abort while port 1 still holds beat 2.
        send_beat(4'b0010, 64'hE000, 1'b0, 4'b0010, st);
        send_beat(4'b0010, 64'hE001, 1'b0, 4'b0000, st);
        m_ready[1] = 1'b0;
        aq.push_back(4'b0010);
        s_abort = 1'b1;
        @(negedge clk);
        chk("abort_held", m_valid, 4'b0010);
        @(posedge clk); #1 s_abort = 1'b0;
        @(negedge clk);
        chk("abort_mvalid", m_valid, 4'b0000);
        @(posedge clk); #1 m_ready[1] = 1'b1;
        send_beat(4'b1000, 64'hE100, 1'b1, 4'b1000, st);
        repeat (2) @(posedge clk); #1;

        // Abort in IDLE with a beat: ignored, nothing produced.
        s_valid = 1'b1; s_abort = 1'b1; s_sel = 4'b0001; s_data = 64'hF000; s_last = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0; s_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_mvalid", m_valid, 4'b0000);
        @(posedge clk); #1;

        // Abort in IDLE while a final beat is still waiting: beat completes.
        send_beat(4'b0001, 64'hF100, 1'b1, 4'b0001, st);
        m_ready[0] = 1'b0;
        s_abort = 1'b1;
        @(posedge clk); #1 s_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_keep", m_valid, 4'b0001);
        @(posedge clk); #1 m_ready[0] = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Reset during beat 2, then a fresh packet with a changing S_SEL.
        send_beat(4'b0100, 64'h9000, 1'b0, 4'b0100, st);
        s_valid = 1'b1; s_data = 64'h9001; rst_n = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_mvalid", m_valid, 4'b0000);
        chk("rstmid_mabort", m_abort, 4'b0000);
        @(posedge clk); #1 rst_n = 1'b1;
        send_beat(4'b0001, 64'h9100, 1'b0, 4'b0001, st);
        send_beat(4'b0100, 64'h9101, 1'b1, 4'b0001, st);
        repeat (4) @(posedge clk); #1;

        for (int k = 0; k < 4; k++)
            chk($sformatf("left_p%0d", k), q[k].size(), 0);
        chk("left_abort", aq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
